// File: rtl/aes_key_sched.sv
// Iterative AES-128 key schedule: emits round keys 0..10, one per rk_valid/rk_ready handshake.
// The SubWord S-box is external. Define AES_KS_STORE_EN to add an 11-entry round-key store with readback.
module aes_key_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done,
    output logic [31:0]  sbox_in,
    input  logic [31:0]  sbox_out
`ifdef AES_KS_STORE_EN
    ,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // GF(2^8) doubling used to advance the round constant
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    state_t       state_q, state_d;
    logic [127:0] w_q, w_d;
    logic [3:0]   idx_q, idx_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         done_q, done_d;
    logic         hs_s;
    logic [31:0]  temp_s, w0n_s, w1n_s, w2n_s, w3n_s;

    // Next-round words, evaluated every cycle and committed only on a handshake
    always_comb begin
        temp_s = sbox_out ^ {rcon_q, 24'h000000};
        w0n_s  = w_q[127:96] ^ temp_s;
        w1n_s  = w_q[95:64]  ^ w0n_s;
        w2n_s  = w_q[63:32]  ^ w1n_s;
        w3n_s  = w_q[31:0]   ^ w2n_s;
    end

    // Sequencer next-state logic
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        hs_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_EMIT;
                    w_d     = key_in;
                    idx_d   = 4'd0;
                    rcon_d  = 8'h01;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (rk_ready) begin
                    hs_s = 1'b1;
                    if (idx_q == 4'd10) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        w_d    = {w0n_s, w1n_s, w2n_s, w3n_s};
                        idx_d  = idx_q + 4'd1;
                        rcon_d = xtime(rcon_q);
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            w_q     <= 128'd0;
            idx_q   <= 4'd0;
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    assign rk_valid = (state_q == ST_EMIT);
    assign busy     = (state_q == ST_EMIT);
    assign rk_out   = w_q;
    assign rk_idx   = idx_q;
    assign done     = done_q;
    // RotWord comes straight off the w3 register so the S-box input is always settled
    assign sbox_in  = {w_q[23:0], w_q[31:24]};

`ifdef AES_KS_STORE_EN
    logic [127:0] store_q [11];
    logic [127:0] store_d [11];
    logic [127:0] rd_key_q, rd_key_d;

    // Capture each accepted round key; read port returns zero outside 0..10
    always_comb begin
        rd_key_d = 128'd0;
        for (int k = 0; k < 11; k++) begin
            if (hs_s && (idx_q == 4'(k))) begin
                store_d[k] = w_q;
            end else begin
                store_d[k] = store_q[k];
            end
            if (rd_idx == 4'(k)) begin
                rd_key_d = store_q[k];
            end else begin
                rd_key_d = rd_key_d;
            end
        end
    end

    // Key store and registered readback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 11; k++) begin
                store_q[k] <= 128'd0;
            end
            rd_key_q <= 128'd0;
        end else begin
            for (int k = 0; k < 11; k++) begin
                store_q[k] <= store_d[k];
            end
            rd_key_q <= rd_key_d;
        end
    end

    assign rd_key = rd_key_q;
`endif

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched: FIPS-197 schedule, backpressure, start-while-busy,
// reset mid-run and back-to-back schedules; store readback when AES_KS_STORE_EN is defined.
module tb_aes_key_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         done;
    logic [31:0]  sbox_in;
    logic [31:0]  sbox_out;
`ifdef AES_KS_STORE_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
`endif

    int errors = 0;
    int checks = 0;
    logic [15:0]  lfsr = 16'hace1;
    logic [127:0] exp_key [11];

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] OTHER_KEY = 128'h00112233445566778899aabbccddeeff;

    logic [2047:0] sbox_flat = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb(input logic [7:0] a);
        int pos;
        pos = 255 - int'(a);
        return sbox_flat[pos*8 +: 8];
    endfunction

    assign sbox_out = {sb(sbox_in[31:24]), sb(sbox_in[23:16]), sb(sbox_in[15:8]), sb(sbox_in[7:0])};

    always #5 clk = ~clk;

    aes_key_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .busy     (busy),
        .done     (done),
        .sbox_in  (sbox_in),
        .sbox_out (sbox_out)
`ifdef AES_KS_STORE_EN
        ,
        .rd_idx   (rd_idx),
        .rd_key   (rd_key)
`endif
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Walks one FIPS-key schedule already loaded; optional random stalls and a start injected at idx 4.
    task automatic expect_seq(input bit rnd, input bit inject);
        int  i;
        int  cyc;
        bit  rdy;
        bit  finished;
        i = 0;
        cyc = 0;
        finished = 1'b0;
        while (cyc < 300 && !finished) begin
            check1("seq_valid", rk_valid, 1'b1);
            check4("seq_idx", rk_idx, 4'(i));
            check128("seq_key", rk_out, exp_key[i]);
            if (rnd) begin
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                rdy = lfsr[0];
            end else begin
                rdy = 1'b1;
            end
            rk_ready = rdy;
            if (inject && i == 4) begin
                start  = 1'b1;
                key_in = OTHER_KEY;
            end
            @(negedge clk);
            cyc++;
            start  = 1'b0;
            key_in = FIPS_KEY;
            if (rdy) begin
                if (i == 10) finished = 1'b1;
                else i++;
            end
        end
        rk_ready = 1'b0;
        check1("seq_complete", finished, 1'b1);
        check1("done_pulse", done, 1'b1);
        check1("done_valid_low", rk_valid, 1'b0);
        check1("done_busy_low", busy, 1'b0);
        @(negedge clk);
        check1("done_one_cycle", done, 1'b0);
    endtask

    task automatic load(input logic [127:0] k);
        key_in = k;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    initial begin
        exp_key[0]  = FIPS_KEY;
        exp_key[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_key[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_key[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_key[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_key[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_key[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_key[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_key[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_key[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_key[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst_n    = 1'b0;
        start    = 1'b0;
        rk_ready = 1'b0;
        key_in   = 128'd0;
`ifdef AES_KS_STORE_EN
        rd_idx   = 4'd0;
`endif
        #12;
        check1("rst_valid", rk_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check128("rst_key", rk_out, 128'd0);
        check4("rst_idx", rk_idx, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check1("idle_valid", rk_valid, 1'b0);

        // FIPS-197 vector, rk_ready held high
        rk_ready = 1'b1;
        load(FIPS_KEY);
        expect_seq(1'b0, 1'b0);

`ifdef AES_KS_STORE_EN
        rd_idx = 4'd10;
        @(negedge clk);
        check128("store_idx10", rd_key, exp_key[10]);
        rd_idx = 4'd0;
        @(negedge clk);
        check128("store_idx0", rd_key, FIPS_KEY);
        rd_idx = 4'd15;
        @(negedge clk);
        check128("store_idx15", rd_key, 128'd0);
`endif

        // Backpressure
        load(FIPS_KEY);
        expect_seq(1'b1, 1'b0);

        // Start while busy is ignored
        load(FIPS_KEY);
        expect_seq(1'b1, 1'b1);

        // Reset mid-run at idx 6
        rk_ready = 1'b1;
        load(FIPS_KEY);
        for (int c = 0; c < 30 && rk_idx != 4'd6; c++) @(negedge clk);
        check4("mid_reach6", rk_idx, 4'd6);
        rst_n = 1'b0;
        #1;
        check1("mid_rst_valid", rk_valid, 1'b0);
        check1("mid_rst_busy", busy, 1'b0);
        check1("mid_rst_done", done, 1'b0);
        check128("mid_rst_key", rk_out, 128'd0);
        check4("mid_rst_idx", rk_idx, 4'd0);
`ifdef AES_KS_STORE_EN
        check128("mid_rst_rdkey", rd_key, 128'd0);
`endif
        rk_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load(FIPS_KEY);
        check4("restart_idx0", rk_idx, 4'd0);
        rk_ready = 1'b1;
        @(negedge clk);
        check4("restart_idx1", rk_idx, 4'd1);
        check128("restart_key1", rk_out, exp_key[1]);
        for (int c = 0; c < 30 && !done; c++) @(negedge clk);
        check1("restart_done", done, 1'b1);
        rk_ready = 1'b0;
        @(negedge clk);

        // Back-to-back: zero key, then all-ones started in the done cycle
        load(128'd0);
        check128("zero_key0", rk_out, 128'd0);
        rk_ready = 1'b1;
        @(negedge clk);
        check4("zero_idx1", rk_idx, 4'd1);
        check128("zero_key1", rk_out, 128'h62636363626363636263636362636363);
        for (int c = 0; c < 30 && !done; c++) @(negedge clk);
        check1("zero_done", done, 1'b1);
        load({128{1'b1}});
        check1("b2b_valid", rk_valid, 1'b1);
        check4("b2b_idx0", rk_idx, 4'd0);
        check128("b2b_key0", rk_out, {128{1'b1}});
        @(negedge clk);
        check128("b2b_key1", rk_out, 128'he8e9e9e917161616e8e9e9e917161616);
        rk_ready = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
